id_decode: RTL and testbench
============================

// Module: id_decode
// PURPOSE
//  Instruction-decode stage of the simple MIPS pipeline. Produces the operation bundle the execute ALU consumes.
//  Bundle: aluop, alusel, operand data, extended immediate, write address, write enable.
//  Decodes the IF/ID instruction, reads the register file, forwards in-flight EX/MEM results.
//  Registers the bundle in an ID/EX pipeline register with a valid/ready handshake on both sides.
// PARAMETERS
//  DATA_W   32  datapath / register width
//  REG_AW   5   register-file address width (32 GPRs, r0 hardwired zero)
// PORTS
//  clk              in   1       single clock, all state on rising edge
//  rst              in   1       synchronous, active-low reset (rst==0 resets on clk edge)
//  id_inst_i        in   32      instruction from IF/ID
//  id_valid_i       in   1       id_inst_i valid
//  id_ready_o       out  1       stage can accept id_inst_i this cycle
//  id_flush_i       in   1       discard held bundle and incoming instruction
//  id_raddr_1_o     out  REG_AW  regfile read addr rs (combinational from id_inst_i)
//  id_raddr_2_o     out  REG_AW  regfile read addr rt
//  id_rf_rdata_1_i  in   DATA_W  regfile read data rs (combinational return)
//  id_rf_rdata_2_i  in   DATA_W  regfile read data rt
//  id_ex_fwd_we_i / id_ex_fwd_waddr_i / id_ex_fwd_wdata_i     in  1/REG_AW/DATA_W  EX-stage result
//  id_mem_fwd_we_i / id_mem_fwd_waddr_i / id_mem_fwd_wdata_i  in  1/REG_AW/DATA_W  MEM-stage result
//  id_aluop_o       out  8       ALU operation code to EX
//  id_alusel_o      out  3       ALU result-select to EX
//  id_rdata_1_o     out  DATA_W  operand 1 to EX
//  id_rdata_2_o     out  DATA_W  operand 2 to EX (imm already substituted for I-type)
//  id_ext_imm_o     out  DATA_W  extended immediate to EX
//  id_waddr_o       out  REG_AW  destination register to EX
//  id_we_o          out  1       destination write enable to EX
//  id_valid_o       out  1       bundle valid
//  ex_ready_i       in   1       EX accepts bundle this cycle
// BEHAVIOUR
//  Reset: every registered output 0 (aluop 8'h00, alusel 3'b000, data 0, waddr 0, we 0, valid 0); id_illegal_o 0.
//  Handshake: id_ready_o = !id_valid_o || ex_ready_i. Load when id_valid_i && id_ready_o && !id_flush_i.
//  Load latency: 1 cycle, id_inst_i to id_valid_o. Full throughput; no bubble when ex_ready_i held high.
//  Hold: id_valid_o && !ex_ready_i keeps all outputs stable; forwarding inputs ignored while held.
//  Drain: ex_ready_i && !(id_valid_i) clears id_valid_o next cycle.
//  Flush: id_flush_i clears id_valid_o and id_we_o next cycle; overrides a simultaneous load.
//  Reset mid-hold: drops the bundle.
//  Decode (sel LOGIC=3'b001, NOP aluop 8'h00/sel 3'b000):
//    SPECIAL funct 0x24/25/26/27 -> aluop AND 8'h24 / OR 8'h25 / XOR 8'h26 / NOR 8'h27; waddr=rd; rs,rt read.
//    ANDI 0x0C, ORI 0x0D, XORI 0x0E -> aluop AND/OR/XOR; waddr=rt; op2=zero-extended imm16.
//    LUI 0x0F -> aluop OR; op1 forced 0; op2=ext_imm={imm16,16'h0}; waddr=rt.
//    ext_imm: zero-extended imm16 for logical I-type, {imm16,16'h0} for LUI, 0 for R-type.
//    SPECIAL all-zero word (sll r0) -> NOP, we=0. Any other encoding -> NOP, we=0.
//    waddr==0 -> id_we_o forced 0.
//  Operand select, per source reg r: r==0 -> 0.
//    Else EX fwd (we && waddr==r) -> EX wdata; else MEM fwd match -> MEM wdata; else regfile data.
//    EX has priority over MEM when both match.
// CONFIGURATION
//  ID_ILLEGAL_FLAG_EN defined: adds port id_illegal_o out 1.
//    id_illegal_o is registered alongside the bundle; set for any undecoded encoding other than the all-zero NOP.
//  ID_ILLEGAL_FLAG_EN undefined: port absent; undecoded words become silent NOPs.
// STRUCTURE
//  Shared package mips_defs_pkg:
//    Opcode/funct constants.
//    ALUOP_* (NOP/AND/OR/XOR/NOR) and ALUSEL_* (NOP/LOGIC) constants, shared with the EX ALU.
//  Sub-module id_fwd_mux: zero/EX/MEM/regfile priority mux, instantiated twice (rs, rt).
//  Top: combinational decoder + ID/EX pipeline register + handshake.
// TESTING
//  Reset, then ori r2,r0,0x00F0; ex_ready=1 -> next cycle aluop 8'h25, sel 3'b001, rdata_2 0x000000F0, waddr 2, we 1, valid 1.
//  or r3,r1,r2; regfile r1=0x11, EX fwd r2=0xAB, MEM fwd r2=0xCD -> rdata_1 0x11, rdata_2 0xAB (EX wins).
//  lui r5,0x1234 -> ext_imm 0x12340000, rdata_1 0, aluop 8'h25, waddr 5.
//  ex_ready=0 for 3 cycles with valid bundle -> outputs stable, id_ready_o=0; release -> next instruction loads.
//  flush asserted with id_valid_i=1 -> id_valid_o=0, id_we_o=0 next cycle; ori to r0 -> we=0.
//  Opcode 0x3F with ID_ILLEGAL_FLAG_EN -> NOP, we=0, id_illegal_o=1; rst=0 mid-hold -> all outputs 0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Opcode/funct encodings and ALU control codes shared by the ID stage and the EX ALU.
package mips_defs_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;

   typedef enum logic [7:0] {
      ALUOP_NOP = 8'h00,
      ALUOP_AND = 8'h24,
      ALUOP_OR  = 8'h25,
      ALUOP_XOR = 8'h26,
      ALUOP_NOR = 8'h27
   } aluop_e;

   typedef enum logic [2:0] {
      ALUSEL_NOP   = 3'b000,
      ALUSEL_LOGIC = 3'b001
   } alusel_e;

   function automatic logic is_logic_funct(input logic [5:0] funct);
      return (funct == FUNCT_AND) || (funct == FUNCT_OR) ||
             (funct == FUNCT_XOR) || (funct == FUNCT_NOR);
   endfunction

endpackage

// File: rtl/id_decode_if.sv
// ID/EX bundle bus: decoded operation plus its valid/ready handshake.
interface id_decode_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic [7:0]        id_aluop_o;
   logic [2:0]        id_alusel_o;
   logic [DATA_W-1:0] id_rdata_1_o;
   logic [DATA_W-1:0] id_rdata_2_o;
   logic [DATA_W-1:0] id_ext_imm_o;
   logic [REG_AW-1:0] id_waddr_o;
   logic              id_we_o;
   logic              id_valid_o;
   logic              ex_ready_i;

   // A bundle transfers on any cycle with id_valid_o && ex_ready_i; while
   // id_valid_o is high and ex_ready_i low, every bundle field holds steady.
   modport master (
      output id_aluop_o, id_alusel_o, id_rdata_1_o, id_rdata_2_o,
             id_ext_imm_o, id_waddr_o, id_we_o, id_valid_o,
      input  ex_ready_i
   );

   modport slave (
      input  id_aluop_o, id_alusel_o, id_rdata_1_o, id_rdata_2_o,
             id_ext_imm_o, id_waddr_o, id_we_o, id_valid_o,
      output ex_ready_i
   );
endinterface

// File: rtl/id_fwd_mux.sv
// Source-operand select for one register: r0 -> 0, then EX result, MEM result, regfile.
module id_fwd_mux #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_we,
   input  logic [REG_AW-1:0] ex_waddr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] data
);

   // EX holds the younger result, so it is tested before MEM.
   always_comb begin
      data = rf_data;
      if (addr == '0) begin
         data = '0;
      end else if (ex_we && (ex_waddr == addr)) begin
         data = ex_wdata;
      end else if (mem_we && (mem_waddr == addr)) begin
         data = mem_wdata;
      end
   end

endmodule

// File: rtl/id_decode.sv
// MIPS ID stage: logical-op decoder, operand forwarding and ID/EX register.
// Define ID_ILLEGAL_FLAG_EN to add the registered id_illegal_o flag.
module id_decode
   import mips_defs_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       id_inst_i,
   input  logic              id_valid_i,
   output logic              id_ready_o,
   input  logic              id_flush_i,
   output logic [REG_AW-1:0] id_raddr_1_o,
   output logic [REG_AW-1:0] id_raddr_2_o,
   input  logic [DATA_W-1:0] id_rf_rdata_1_i,
   input  logic [DATA_W-1:0] id_rf_rdata_2_i,
   input  logic              id_ex_fwd_we_i,
   input  logic [REG_AW-1:0] id_ex_fwd_waddr_i,
   input  logic [DATA_W-1:0] id_ex_fwd_wdata_i,
   input  logic              id_mem_fwd_we_i,
   input  logic [REG_AW-1:0] id_mem_fwd_waddr_i,
   input  logic [DATA_W-1:0] id_mem_fwd_wdata_i,
   id_decode_if.master       ex_bus
`ifdef ID_ILLEGAL_FLAG_EN
   ,
   output logic              id_illegal_o
`endif
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [REG_AW-1:0] rs_a;
   logic [REG_AW-1:0] rt_a;
   logic [REG_AW-1:0] rd_a;
   logic [15:0]       imm16;
   logic [DATA_W-1:0] zext_imm;
   logic [DATA_W-1:0] lui_imm;
   logic [DATA_W-1:0] src_1;
   logic [DATA_W-1:0] src_2;

   assign opcode   = id_inst_i[31:26];
   assign rs_a     = id_inst_i[21 +: REG_AW];
   assign rt_a     = id_inst_i[16 +: REG_AW];
   assign rd_a     = id_inst_i[11 +: REG_AW];
   assign funct    = id_inst_i[5:0];
   assign imm16    = id_inst_i[15:0];
   assign zext_imm = {{(DATA_W-16){1'b0}}, imm16};
   assign lui_imm  = {imm16, {(DATA_W-16){1'b0}}};

   assign id_raddr_1_o = rs_a;
   assign id_raddr_2_o = rt_a;

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .addr      (rs_a),
      .rf_data   (id_rf_rdata_1_i),
      .ex_we     (id_ex_fwd_we_i),
      .ex_waddr  (id_ex_fwd_waddr_i),
      .ex_wdata  (id_ex_fwd_wdata_i),
      .mem_we    (id_mem_fwd_we_i),
      .mem_waddr (id_mem_fwd_waddr_i),
      .mem_wdata (id_mem_fwd_wdata_i),
      .data      (src_1)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .addr      (rt_a),
      .rf_data   (id_rf_rdata_2_i),
      .ex_we     (id_ex_fwd_we_i),
      .ex_waddr  (id_ex_fwd_waddr_i),
      .ex_wdata  (id_ex_fwd_wdata_i),
      .mem_we    (id_mem_fwd_we_i),
      .mem_waddr (id_mem_fwd_waddr_i),
      .mem_wdata (id_mem_fwd_wdata_i),
      .data      (src_2)
   );

   aluop_e            dec_aluop;
   alusel_e           dec_alusel;
   logic [DATA_W-1:0] dec_op1;
   logic [DATA_W-1:0] dec_op2;
   logic [DATA_W-1:0] dec_imm;
   logic [REG_AW-1:0] dec_waddr;
   logic              dec_we;
   logic              dec_illegal;

   // Undecoded words fall through as a NOP with all operands zeroed.
   always_comb begin
      dec_aluop   = ALUOP_NOP;
      dec_alusel  = ALUSEL_NOP;
      dec_op1     = '0;
      dec_op2     = '0;
      dec_imm     = '0;
      dec_waddr   = '0;
      dec_we      = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            if (is_logic_funct(funct)) begin
               case (funct)
                  FUNCT_AND: dec_aluop = ALUOP_AND;
                  FUNCT_OR:  dec_aluop = ALUOP_OR;
                  FUNCT_XOR: dec_aluop = ALUOP_XOR;
                  default:   dec_aluop = ALUOP_NOR;
               endcase
               dec_alusel = ALUSEL_LOGIC;
               dec_op1    = src_1;
               dec_op2    = src_2;
               dec_waddr  = rd_a;
               dec_we     = 1'b1;
            end else begin
               dec_illegal = (id_inst_i != 32'h0);
            end
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            case (opcode)
               OP_ANDI: dec_aluop = ALUOP_AND;
               OP_ORI:  dec_aluop = ALUOP_OR;
               default: dec_aluop = ALUOP_XOR;
            endcase
            dec_alusel = ALUSEL_LOGIC;
            dec_op1    = src_1;
            dec_op2    = zext_imm;
            dec_imm    = zext_imm;
            dec_waddr  = rt_a;
            dec_we     = 1'b1;
         end
         OP_LUI: begin
            dec_aluop  = ALUOP_OR;
            dec_alusel = ALUSEL_LOGIC;
            dec_op2    = lui_imm;
            dec_imm    = lui_imm;
            dec_waddr  = rt_a;
            dec_we     = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      if (dec_waddr == '0) begin
         dec_we = 1'b0;
      end
   end

   logic load;
   assign id_ready_o = !ex_bus.id_valid_o || ex_bus.ex_ready_i;
   assign load       = id_valid_i && id_ready_o && !id_flush_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_bus.id_aluop_o   <= ALUOP_NOP;
         ex_bus.id_alusel_o  <= ALUSEL_NOP;
         ex_bus.id_rdata_1_o <= '0;
         ex_bus.id_rdata_2_o <= '0;
         ex_bus.id_ext_imm_o <= '0;
         ex_bus.id_waddr_o   <= '0;
         ex_bus.id_we_o      <= 1'b0;
         ex_bus.id_valid_o   <= 1'b0;
      end else if (id_flush_i) begin
         ex_bus.id_we_o      <= 1'b0;
         ex_bus.id_valid_o   <= 1'b0;
      end else if (load) begin
         ex_bus.id_aluop_o   <= dec_aluop;
         ex_bus.id_alusel_o  <= dec_alusel;
         ex_bus.id_rdata_1_o <= dec_op1;
         ex_bus.id_rdata_2_o <= dec_op2;
         ex_bus.id_ext_imm_o <= dec_imm;
         ex_bus.id_waddr_o   <= dec_waddr;
         ex_bus.id_we_o      <= dec_we;
         ex_bus.id_valid_o   <= 1'b1;
      end else if (ex_bus.ex_ready_i) begin
         ex_bus.id_valid_o   <= 1'b0;
      end
   end

`ifdef ID_ILLEGAL_FLAG_EN
   always_ff @(posedge clk) begin
      if (!rst || id_flush_i) begin
         id_illegal_o <= 1'b0;
      end else if (load) begin
         id_illegal_o <= dec_illegal;
      end
   end
`else
   logic unused_illegal;
   assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_id_decode.sv
// Directed plus randomized bench for id_decode against a behavioural decode/handshake model.
module tb_id_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] id_inst_i = '0;
   logic        id_valid_i = 1'b0;
   logic        id_ready_o;
   logic        id_flush_i = 1'b0;
   logic [4:0]  id_raddr_1_o;
   logic [4:0]  id_raddr_2_o;
   logic [31:0] rf1 = '0;
   logic [31:0] rf2 = '0;
   logic        ex_we = 1'b0;
   logic [4:0]  ex_wa = '0;
   logic [31:0] ex_wd = '0;
   logic        mem_we = 1'b0;
   logic [4:0]  mem_wa = '0;
   logic [31:0] mem_wd = '0;
`ifdef ID_ILLEGAL_FLAG_EN
   logic        id_illegal_o;
`endif

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_decode_if bus ();

   id_decode dut (
      .clk                (clk),
      .rst                (rst),
      .id_inst_i          (id_inst_i),
      .id_valid_i         (id_valid_i),
      .id_ready_o         (id_ready_o),
      .id_flush_i         (id_flush_i),
      .id_raddr_1_o       (id_raddr_1_o),
      .id_raddr_2_o       (id_raddr_2_o),
      .id_rf_rdata_1_i    (rf1),
      .id_rf_rdata_2_i    (rf2),
      .id_ex_fwd_we_i     (ex_we),
      .id_ex_fwd_waddr_i  (ex_wa),
      .id_ex_fwd_wdata_i  (ex_wd),
      .id_mem_fwd_we_i    (mem_we),
      .id_mem_fwd_waddr_i (mem_wa),
      .id_mem_fwd_wdata_i (mem_wd),
      .ex_bus             (bus)
`ifdef ID_ILLEGAL_FLAG_EN
      ,
      .id_illegal_o       (id_illegal_o)
`endif
   );

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  sel;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] imm;
      logic [4:0]  waddr;
      logic        we;
      logic        illegal;
   } bundle_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] src(input logic [4:0] r, input logic [31:0] rfv);
      if (r == 5'd0) return 32'h0;
      if (ex_we && ex_wa == r) return ex_wd;
      if (mem_we && mem_wa == r) return mem_wd;
      return rfv;
   endfunction

   // Reference decode built from the instruction-set rules.
   function automatic bundle_t ref_decode(input logic [31:0] w);
      bundle_t b;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
      b = '0;
      if (op == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
         b.aluop = 8'h24 + 8'(fn - 6'h24);
         b.sel = 3'b001; b.op1 = src(rs, rf1); b.op2 = src(rt, rf2);
         b.waddr = rd; b.we = (rd != 5'd0);
      end else if (op >= 6'h0C && op <= 6'h0E) begin
         b.aluop = 8'h24 + 8'(op - 6'h0C);
         b.sel = 3'b001; b.op1 = src(rs, rf1); b.op2 = {16'h0, w[15:0]}; b.imm = b.op2;
         b.waddr = rt; b.we = (rt != 5'd0);
      end else if (op == 6'h0F) begin
         b.aluop = 8'h25; b.sel = 3'b001; b.op2 = {w[15:0], 16'h0}; b.imm = b.op2;
         b.waddr = rt; b.we = (rt != 5'd0);
      end else begin
         b.illegal = (w != 32'h0);
      end
      return b;
   endfunction

   task automatic chk_bundle(input string tag, input bundle_t e);
      chk({tag, ".aluop"}, {24'h0, bus.id_aluop_o}, {24'h0, e.aluop});
      chk({tag, ".sel"}, {29'h0, bus.id_alusel_o}, {29'h0, e.sel});
      chk({tag, ".rdata_1"}, bus.id_rdata_1_o, e.op1);
      chk({tag, ".rdata_2"}, bus.id_rdata_2_o, e.op2);
      chk({tag, ".ext_imm"}, bus.id_ext_imm_o, e.imm);
      chk({tag, ".waddr"}, {27'h0, bus.id_waddr_o}, {27'h0, e.waddr});
      chk({tag, ".we"}, {31'h0, bus.id_we_o}, {31'h0, e.we});
`ifdef ID_ILLEGAL_FLAG_EN
      chk({tag, ".illegal"}, {31'h0, id_illegal_o}, {31'h0, e.illegal});
`endif
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
         0: return {6'h00, rs, rt, rd, 5'h0, 6'(6'h24 + 6'($urandom_range(0, 3)))};
         1: return {6'(6'h0C + 6'($urandom_range(0, 2))), rs, rt, 16'($urandom)};
         2: return {6'h0F, rs, rt, 16'($urandom)};
         3: return 32'h0;
         4: return $urandom;
         default: return {6'h00, rs, rt, rd, 5'h0, 6'($urandom_range(0, 35))};
      endcase
   endfunction

   bundle_t cur;
   bundle_t nb;
   logic    cur_valid;
   logic    flushed;

   initial begin
      // Reset state
      rst = 1'b0; bus.ex_ready_i = 1'b1;
      tick(); tick();
      chk("rst.valid", {31'h0, bus.id_valid_o}, 32'h0);
      chk_bundle("rst", '0);
      chk("rst.ready", {31'h0, id_ready_o}, 32'h1);
      rst = 1'b1;

      // ori r2,r0,0x00F0
      id_inst_i = 32'h340200F0; id_valid_i = 1'b1; rf1 = 32'h5555AAAA; rf2 = 32'h0BADF00D;
      #1;
      chk("ori.raddr_1", {27'h0, id_raddr_1_o}, 32'd0);
      chk("ori.raddr_2", {27'h0, id_raddr_2_o}, 32'd2);
      tick();
      chk("ori.valid", {31'h0, bus.id_valid_o}, 32'h1);
      chk_bundle("ori", '{aluop: 8'h25, sel: 3'b001, op1: 32'h0, op2: 32'h000000F0,
                          imm: 32'h000000F0, waddr: 5'd2, we: 1'b1, illegal: 1'b0});

      // or r3,r1,r2 with both forwards hitting r2
      id_inst_i = 32'h00221825; rf1 = 32'h11; rf2 = 32'h99;
      ex_we = 1'b1; ex_wa = 5'd2; ex_wd = 32'hAB;
      mem_we = 1'b1; mem_wa = 5'd2; mem_wd = 32'hCD;
      tick();
      chk("or.valid", {31'h0, bus.id_valid_o}, 32'h1);
      chk_bundle("or", '{aluop: 8'h25, sel: 3'b001, op1: 32'h11, op2: 32'hAB,
                         imm: 32'h0, waddr: 5'd3, we: 1'b1, illegal: 1'b0});

      // lui r5,0x1234 with nonzero rs field
      id_inst_i = 32'h3CE51234; rf1 = 32'hDEAD; ex_we = 1'b0; mem_we = 1'b0;
      tick();
      chk_bundle("lui", '{aluop: 8'h25, sel: 3'b001, op1: 32'h0, op2: 32'h12340000,
                          imm: 32'h12340000, waddr: 5'd5, we: 1'b1, illegal: 1'b0});

      // xori r4,r1,0xFFFF then hold three cycles
      id_inst_i = 32'h3824FFFF; rf1 = 32'h0F0F0F0F;
      tick();
      chk_bundle("xori", '{aluop: 8'h26, sel: 3'b001, op1: 32'h0F0F0F0F, op2: 32'h0000FFFF,
                           imm: 32'h0000FFFF, waddr: 5'd4, we: 1'b1, illegal: 1'b0});
      bus.ex_ready_i = 1'b0;
      id_inst_i = 32'h302600FF; rf1 = 32'h12345678;
      ex_we = 1'b1; ex_wa = 5'd1; ex_wd = 32'h77;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold.ready", {31'h0, id_ready_o}, 32'h0);
         chk("hold.valid", {31'h0, bus.id_valid_o}, 32'h1);
         chk_bundle("hold", '{aluop: 8'h26, sel: 3'b001, op1: 32'h0F0F0F0F, op2: 32'h0000FFFF,
                              imm: 32'h0000FFFF, waddr: 5'd4, we: 1'b1, illegal: 1'b0});
      end
      bus.ex_ready_i = 1'b1;
      #1;
      chk("release.ready", {31'h0, id_ready_o}, 32'h1);
      tick();
      chk_bundle("andi", '{aluop: 8'h24, sel: 3'b001, op1: 32'h77, op2: 32'h000000FF,
                           imm: 32'h000000FF, waddr: 5'd6, we: 1'b1, illegal: 1'b0});
      ex_we = 1'b0;

      // Flush wins over a simultaneous load
      id_inst_i = 32'h340700F0; id_flush_i = 1'b1;
      tick();
      chk("flush.valid", {31'h0, bus.id_valid_o}, 32'h0);
      chk("flush.we", {31'h0, bus.id_we_o}, 32'h0);
      id_flush_i = 1'b0;

      // ori to r0 never writes
      id_inst_i = 32'h34205555;
      tick();
      chk("ori_r0.valid", {31'h0, bus.id_valid_o}, 32'h1);
      chk("ori_r0.we", {31'h0, bus.id_we_o}, 32'h0);
      chk("ori_r0.aluop", {24'h0, bus.id_aluop_o}, 32'h25);

      // Undecoded opcode 0x3F and the all-zero NOP
      id_inst_i = 32'hFC000000;
      tick();
      chk("ill.aluop", {24'h0, bus.id_aluop_o}, 32'h0);
      chk("ill.sel", {29'h0, bus.id_alusel_o}, 32'h0);
      chk("ill.we", {31'h0, bus.id_we_o}, 32'h0);
`ifdef ID_ILLEGAL_FLAG_EN
      chk("ill.flag", {31'h0, id_illegal_o}, 32'h1);
`endif
      id_inst_i = 32'h0;
      tick();
      chk("nop.aluop", {24'h0, bus.id_aluop_o}, 32'h0);
      chk("nop.we", {31'h0, bus.id_we_o}, 32'h0);
`ifdef ID_ILLEGAL_FLAG_EN
      chk("nop.flag", {31'h0, id_illegal_o}, 32'h0);
`endif

      // Reset while a bundle is held
      id_inst_i = 32'h340200F0;
      tick();
      bus.ex_ready_i = 1'b0; id_valid_i = 1'b0;
      tick();
      chk("prehold.valid", {31'h0, bus.id_valid_o}, 32'h1);
      rst = 1'b0;
      tick();
      chk("rsthold.valid", {31'h0, bus.id_valid_o}, 32'h0);
      chk_bundle("rsthold", '0);
      rst = 1'b1; bus.ex_ready_i = 1'b1;

      // Randomized traffic against the handshake/decode model
      cur = '0; cur_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         id_inst_i = rand_inst();
         id_valid_i = ($urandom_range(0, 3) != 0);
         id_flush_i = ($urandom_range(0, 15) == 0);
         bus.ex_ready_i = ($urandom_range(0, 3) != 0);
         rf1 = $urandom; rf2 = $urandom;
         ex_we = 1'($urandom_range(0, 1)); ex_wa = 5'($urandom_range(0, 3)); ex_wd = $urandom;
         mem_we = 1'($urandom_range(0, 1)); mem_wa = 5'($urandom_range(0, 3)); mem_wd = $urandom;
         #1;
         chk("rnd.ready", {31'h0, id_ready_o}, {31'h0, !cur_valid || bus.ex_ready_i});
         chk("rnd.raddr_1", {27'h0, id_raddr_1_o}, {27'h0, id_inst_i[25:21]});
         nb = ref_decode(id_inst_i);
         flushed = id_flush_i;
         if (id_flush_i) begin
            cur_valid = 1'b0; cur.we = 1'b0;
         end else if (id_valid_i && (!cur_valid || bus.ex_ready_i)) begin
            cur = nb; cur_valid = 1'b1;
         end else if (bus.ex_ready_i) begin
            cur_valid = 1'b0;
         end
         tick();
         chk("rnd.valid", {31'h0, bus.id_valid_o}, {31'h0, cur_valid});
         if (cur_valid) chk_bundle("rnd", cur);
         if (flushed) chk("rnd.flush_we", {31'h0, bus.id_we_o}, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
